// File: rtl/stage_mm_bus_pkg.sv
// Shared constants for the EX->M memory stage: control field layout,
// access width codes, exception codes and FSM encoding.
package stage_mm_bus_pkg;

  // Layout of in_mctl, MSB first: {re, we, ext, width[1:0], grf_we}
  typedef struct packed {
    logic       re;
    logic       we;
    logic       ext;
    logic [1:0] width;
    logic       grf_we;
  } mctl_t;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;  // 2'd3 also means word

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;
  localparam logic [1:0] EXC_BUS  = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mm_state_e;

  // Natural-alignment check for a given access width and low address bits
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] ao_lo);
    logic mis;
    case (width)
      WIDTH_BYTE: mis = 1'b0;
      WIDTH_HALF: mis = ao_lo[0];
      default:    mis = |ao_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/stage_mm_bus_lane.sv
// Byte-lane steering for stores and alignment/extension for loads.
module mm_lane
  import stage_mm_bus_pkg::*;
(
  input  logic [1:0]  ao_lo,
  input  logic [1:0]  width,
  input  logic        ext,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted_s;

  // Store side: byte enables and replicated write data per access width
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0000_0000;
    case (width)
      WIDTH_BYTE: begin
        be    = 4'b0001 << ao_lo;
        wdata = {4{rt[7:0]}};
      end
      WIDTH_HALF: begin
        be    = 4'b0011 << ao_lo;
        wdata = {2{rt[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = rt;
      end
    endcase
  end

  // Load side: move the addressed lane to bit 0, then truncate and extend
  always_comb begin
    shifted_s = rdata >> {ao_lo, 3'b000};
    load_data = 32'h0000_0000;
    case (width)
      WIDTH_BYTE: load_data = {{24{ext & shifted_s[7]}}, shifted_s[7:0]};
      WIDTH_HALF: load_data = {{16{ext & shifted_s[15]}}, shifted_s[15:0]};
      default:    load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/stage_mm_bus.sv
// Memory pipeline stage: holds the EX->M register, runs a single outstanding
// bus access (IDLE/ACCESS), stalls upstream while the bus is busy, and
// reports alignment, bus-error and timeout exceptions toward WB.
module stage_mm_bus
  import stage_mm_bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [31:0]   in_pc4,
  input  logic [31:0]   in_ir,
  input  logic [31:0]   in_ao,
  input  logic [31:0]   in_rt,
  input  logic [5:0]    in_mctl,
  input  logic [4:0]    in_a3,
  output logic          stall,
  output logic          out_valid,
  output logic [31:0]   out_pc4,
  output logic [31:0]   out_ir,
  output logic [4:0]    out_a3,
  output logic          out_grf_we,
  output logic [31:0]   out_wd,
  output logic          mem_to_reg,
  output logic [1:0]    exc_code,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // M register and FSM state
  logic        valid_q, valid_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ao_q, ao_d;
  logic [31:0] rt_q, rt_d;
  mctl_t       mctl_q, mctl_d;
  logic [4:0]  a3_q, a3_d;
  mm_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  mctl_t       in_mctl_s;
  logic        start_s;
  logic        access_s;
  logic        tmo_s;
  logic        ack_s;
  logic        cap_s;
  logic        mis_q_s;
  logic [3:0]  lane_be_s;
  logic [31:0] lane_wdata_s;
  logic [31:0] lane_load_s;

  assign in_mctl_s = mctl_t'(in_mctl);
  // A captured slot needs the bus only if it is real, a memory op, and aligned
  assign start_s   = in_valid & (in_mctl_s.re | in_mctl_s.we)
                     & ~is_misaligned(in_mctl_s.width, in_ao[1:0]);

  assign access_s  = (state_q == ST_ACCESS);
  // Timeout cycle: counter has reached the limit; the request is withdrawn here
  assign tmo_s     = access_s && (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
  assign bus_req   = access_s & ~tmo_s;
  assign ack_s     = bus_req & bus_ack;
  assign stall     = bus_req & ~bus_ack;
  assign cap_s     = ~stall;
  assign mis_q_s   = is_misaligned(mctl_q.width, ao_q[1:0]);

  mm_lane u_lane (
    .ao_lo     (ao_q[1:0]),
    .width     (mctl_q.width),
    .ext       (mctl_q.ext),
    .rt        (rt_q),
    .rdata     (bus_rdata),
    .be        (lane_be_s),
    .wdata     (lane_wdata_s),
    .load_data (lane_load_s)
  );

  // Next-state for the M register: capture when not stalled, otherwise hold
  always_comb begin
    if (cap_s) begin
      valid_d = in_valid;
      pc4_d   = in_pc4;
      ir_d    = in_ir;
      ao_d    = in_ao;
      rt_d    = in_rt;
      mctl_d  = in_mctl_s;
      a3_d    = in_a3;
    end else begin
      valid_d = valid_q;
      pc4_d   = pc4_q;
      ir_d    = ir_q;
      ao_d    = ao_q;
      rt_d    = rt_q;
      mctl_d  = mctl_q;
      a3_d    = a3_q;
    end
  end

  // Next-state for the FSM and the ACCESS-cycle counter
  always_comb begin
    if (cap_s) begin
      state_d = start_s ? ST_ACCESS : ST_IDLE;
      cnt_d   = {CW{1'b0}};
    end else begin
      state_d = ST_ACCESS;
      if (TIMEOUT != 0) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc4_q   <= 32'h0000_0000;
      ir_q    <= 32'h0000_0000;
      ao_q    <= 32'h0000_0000;
      rt_q    <= 32'h0000_0000;
      mctl_q  <= 6'b000000;
      a3_q    <= 5'd0;
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      valid_q <= valid_d;
      pc4_q   <= pc4_d;
      ir_q    <= ir_d;
      ao_q    <= ao_d;
      rt_q    <= rt_d;
      mctl_q  <= mctl_d;
      a3_q    <= a3_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Exception priority: alignment, then timeout, then bus error on ack
  always_comb begin
    if (!valid_q) begin
      exc_code = EXC_NONE;
    end else if ((mctl_q.re | mctl_q.we) & mis_q_s) begin
      exc_code = mctl_q.re ? EXC_ADEL : EXC_ADES;
    end else if (tmo_s) begin
      exc_code = EXC_BUS;
    end else if (ack_s & bus_err) begin
      exc_code = EXC_BUS;
    end else begin
      exc_code = EXC_NONE;
    end
  end

  // Bus side is driven only while requesting so an idle bus is all-zero
  assign bus_we    = bus_req & mctl_q.we;
  assign bus_addr  = bus_req ? {ao_q[AW-1:2], 2'b00} : {AW{1'b0}};
  assign bus_be    = bus_req ? lane_be_s : 4'b0000;
  assign bus_wdata = bus_req ? lane_wdata_s : 32'h0000_0000;

  // A slot is presented to WB only once the bus is done with it
  assign out_valid  = valid_q & ~stall;
  assign out_pc4    = pc4_q;
  assign out_ir     = ir_q;
  assign out_a3     = a3_q;
  assign out_grf_we = out_valid & mctl_q.grf_we & (exc_code == EXC_NONE);
  assign out_wd     = mctl_q.re ? lane_load_s : ao_q;
  assign mem_to_reg = valid_q & mctl_q.re & mctl_q.grf_we;

endmodule

// File: tb/tb_stage_mm_bus.sv
// Directed bench for stage_mm_bus: loads, stores, back-to-back access,
// alignment and bus exceptions, timeout and asynchronous reset.
module tb_stage_mm_bus;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc4, in_ir, in_ao, in_rt;
  logic [5:0]  in_mctl;
  logic [4:0]  in_a3;
  logic        stall, out_valid, out_grf_we, mem_to_reg, bus_req, bus_we;
  logic [31:0] out_pc4, out_ir, out_wd, bus_addr, bus_wdata;
  logic [4:0]  out_a3;
  logic [1:0]  exc_code;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stage_mm_bus #(.AW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc4(in_pc4), .in_ir(in_ir),
    .in_ao(in_ao), .in_rt(in_rt), .in_mctl(in_mctl), .in_a3(in_a3), .stall(stall),
    .out_valid(out_valid), .out_pc4(out_pc4), .out_ir(out_ir), .out_a3(out_a3),
    .out_grf_we(out_grf_we), .out_wd(out_wd), .mem_to_reg(mem_to_reg), .exc_code(exc_code),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic drive(input logic v, input logic [31:0] pc4, input logic [31:0] ao,
                       input logic [31:0] rt, input logic [5:0] mctl, input logic [4:0] a3);
    in_valid = v; in_pc4 = pc4; in_ir = pc4 ^ 32'hA5A5_0000; in_ao = ao;
    in_rt = rt; in_mctl = mctl; in_a3 = a3;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %0b want 0", stall); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %0b want 0", bus_req); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    n_cmp++; if (exc_code !== 2'd0) begin n_bad++; $display("FAIL rst_exc got %0d want 0", exc_code); end
    // first capture on the first rising edge after release: ALU op
    rst_n = 1'b1;
    drive(1'b1, 32'h0000_1004, 32'h0000_55AA, 32'h0, 6'b000001, 5'd3);
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 32'h0, 6'b000000, 5'd0); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL alu_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_pc4 !== 32'h0000_1004) begin n_bad++; $display("FAIL alu_pc4 got %h want 00001004", out_pc4); end
    n_cmp++; if (out_wd !== 32'h0000_55AA) begin n_bad++; $display("FAIL alu_wd got %h want 000055aa", out_wd); end
    n_cmp++; if (out_grf_we !== 1'b1) begin n_bad++; $display("FAIL alu_grf got %0b want 1", out_grf_we); end
    n_cmp++; if (out_a3 !== 5'd3) begin n_bad++; $display("FAIL alu_a3 got %0d want 3", out_a3); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL alu_req got %0b want 0", bus_req); end
  endtask

  task automatic test_lw();
    drive(1'b1, 32'h0000_2004, 32'h0000_0100, 32'h0, 6'b100101, 5'd7);
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 32'h0, 6'b000000, 5'd0); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lw_stall1 got %0b want 1", stall); end
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL lw_req got %0b want 1", bus_req); end
    n_cmp++; if (bus_be !== 4'b1111) begin n_bad++; $display("FAIL lw_be got %b want 1111", bus_be); end
    n_cmp++; if (bus_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL lw_addr got %h want 00000100", bus_addr); end
    n_cmp++; if (bus_we !== 1'b0) begin n_bad++; $display("FAIL lw_we got %0b want 0", bus_we); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lw_valid_stalled got %0b want 0", out_valid); end
    @(negedge clk); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lw_stall2 got %0b want 1", stall); end
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lw_stall3 got %0b want 0", stall); end
    n_cmp++; if (out_wd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_wd got %h want deadbeef", out_wd); end
    n_cmp++; if (out_grf_we !== 1'b1) begin n_bad++; $display("FAIL lw_grf got %0b want 1", out_grf_we); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lw_valid got %0b want 1", out_valid); end
    n_cmp++; if (mem_to_reg !== 1'b1) begin n_bad++; $display("FAIL lw_m2r got %0b want 1", mem_to_reg); end
    n_cmp++; if (out_a3 !== 5'd7) begin n_bad++; $display("FAIL lw_a3 got %0d want 7", out_a3); end
    @(negedge clk); bus_ack = 1'b0; #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL lw_idle_req got %0b want 0", bus_req); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h0000_3004, 32'h0000_0103, 32'h0, 6'b101001, 5'd8);
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'h80FF_FFFF;
    drive(1'b1, 32'h0000_3008, 32'h0000_0103, 32'h0, 6'b100001, 5'd9); #1;
    n_cmp++; if (bus_be !== 4'b1000) begin n_bad++; $display("FAIL lb_be got %b want 1000", bus_be); end
    n_cmp++; if (out_wd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_sext got %h want ffffff80", out_wd); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lb_stall got %0b want 0", stall); end
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 32'h0, 6'b000000, 5'd0); #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL b2b_req got %0b want 1", bus_req); end
    n_cmp++; if (out_wd !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_zext got %h want 00000080", out_wd); end
    n_cmp++; if (out_a3 !== 5'd9) begin n_bad++; $display("FAIL b2b_a3 got %0d want 9", out_a3); end
    @(negedge clk); bus_ack = 1'b0; #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %0b want 0", bus_req); end
  endtask

  task automatic test_store();
    drive(1'b1, 32'h0000_4004, 32'h0000_0202, 32'h1234_ABCD, 6'b010010, 5'd0);
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 32'h0, 6'b000000, 5'd0); #1;
    n_cmp++; if (bus_be !== 4'b1100) begin n_bad++; $display("FAIL sh_be got %b want 1100", bus_be); end
    n_cmp++; if (bus_wdata !== 32'hABCD_ABCD) begin n_bad++; $display("FAIL sh_wdata got %h want abcdabcd", bus_wdata); end
    n_cmp++; if (bus_we !== 1'b1) begin n_bad++; $display("FAIL sh_we got %0b want 1", bus_we); end
    n_cmp++; if (bus_addr !== 32'h0000_0200) begin n_bad++; $display("FAIL sh_addr got %h want 00000200", bus_addr); end
    bus_ack = 1'b1; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sh_stall got %0b want 0", stall); end
    n_cmp++; if (out_grf_we !== 1'b0) begin n_bad++; $display("FAIL sh_grf got %0b want 0", out_grf_we); end
    @(negedge clk); bus_ack = 1'b0;
  endtask

  task automatic test_bus_err();
    drive(1'b1, 32'h0000_5004, 32'h0000_0300, 32'h0, 6'b100101, 5'd4);
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 32'h0, 6'b000000, 5'd0);
    bus_ack = 1'b1; bus_err = 1'b1; #1;
    n_cmp++; if (exc_code !== 2'd3) begin n_bad++; $display("FAIL err_exc got %0d want 3", exc_code); end
    n_cmp++; if (out_grf_we !== 1'b0) begin n_bad++; $display("FAIL err_grf got %0b want 0", out_grf_we); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL err_valid got %0b want 1", out_valid); end
    @(negedge clk); bus_ack = 1'b0; bus_err = 1'b0; #1;
    n_cmp++; if (exc_code !== 2'd0) begin n_bad++; $display("FAIL err_clear got %0d want 0", exc_code); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 32'h0000_6004, 32'h0000_0101, 32'h0, 6'b100101, 5'd6);
    @(negedge clk); drive(1'b1, 32'h0000_6008, 32'h0000_0201, 32'h0, 6'b010010, 5'd0); #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL adel_req got %0b want 0", bus_req); end
    n_cmp++; if (exc_code !== 2'd1) begin n_bad++; $display("FAIL adel_exc got %0d want 1", exc_code); end
    n_cmp++; if (out_grf_we !== 1'b0) begin n_bad++; $display("FAIL adel_grf got %0b want 0", out_grf_we); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL adel_stall got %0b want 0", stall); end
    @(negedge clk); drive(1'b0, 32'h0, 32'h0000_0100, 32'h0, 6'b100101, 5'd5); #1;
    n_cmp++; if (exc_code !== 2'd2) begin n_bad++; $display("FAIL ades_exc got %0d want 2", exc_code); end
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL ades_req got %0b want 0", bus_req); end
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 32'h0, 6'b000000, 5'd0); #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL bub_req got %0b want 0", bus_req); end
    n_cmp++; if (mem_to_reg !== 1'b0) begin n_bad++; $display("FAIL bub_m2r got %0b want 0", mem_to_reg); end
    n_cmp++; if (out_grf_we !== 1'b0) begin n_bad++; $display("FAIL bub_grf got %0b want 0", out_grf_we); end
  endtask

  task automatic test_timeout();
    int n_req;
    n_req = 0;
    drive(1'b1, 32'h0000_7004, 32'h0000_0400, 32'h0, 6'b100101, 5'd2);
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 32'h0, 6'b000000, 5'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!bus_req) break;
      n_req++;
      @(negedge clk);
    end
    n_cmp++; if (n_req !== 4) begin n_bad++; $display("FAIL tmo_req_cycles got %0d want 4", n_req); end
    n_cmp++; if (exc_code !== 2'd3) begin n_bad++; $display("FAIL tmo_exc got %0d want 3", exc_code); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL tmo_stall got %0b want 0", stall); end
    n_cmp++; if (out_grf_we !== 1'b0) begin n_bad++; $display("FAIL tmo_grf got %0b want 0", out_grf_we); end
    @(negedge clk); #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL tmo_idle got %0b want 0", bus_req); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h0000_8004, 32'h0000_0500, 32'h0, 6'b100101, 5'd1);
    @(negedge clk); drive(1'b0, 32'h0, 32'h0, 32'h0, 6'b000000, 5'd0); #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL mid_pre_req got %0b want 1", bus_req); end
    #1 rst_n = 1'b0; #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL mid_req got %0b want 0", bus_req); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_stall got %0b want 0", stall); end
    n_cmp++; if (bus_addr !== 32'h0 || bus_be !== 4'b0000) begin n_bad++; $display("FAIL mid_bus got %h/%b want 0/0", bus_addr, bus_be); end
    n_cmp++; if (out_pc4 !== 32'h0 || out_wd !== 32'h0) begin n_bad++; $display("FAIL mid_out got %h/%h want 0/0", out_pc4, out_wd); end
    n_cmp++; if (out_valid !== 1'b0 || exc_code !== 2'd0) begin n_bad++; $display("FAIL mid_valid_exc got %0b/%0d want 0/0", out_valid, exc_code); end
  endtask

  initial begin
    rst_n = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 6'b000000, 5'd0);
    repeat (2) @(negedge clk);
    test_reset();
    test_lw();
    test_back_to_back();
    test_store();
    test_bus_err();
    test_misalign();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_mm_bus.md
STAGE_MM_BUS -- requirements
Module: stage_mm_bus

Interface
REQ-001 SHALL have parameter AW, default 32: bus address width, 16..32.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles before forced abort; 0 disables the timeout.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  EX->M slot holds a real instruction (0 = bubble).
REQ-006 in_pc4  in  32  PC+4 of the EX instruction.
REQ-007 in_ir  in  32  instruction word.
REQ-008 in_ao  in  32  ALU result / effective address.
REQ-009 in_rt  in  32  store data.
REQ-010 in_mctl  in  6  {re, we, ext, width[1:0], grf_we}; width 0=byte, 1=half, 2/3=word; ext=1 sign-extend.
REQ-011 in_a3  in  5  destination register.
REQ-012 stall  out  1  freeze EX->M capture and all upstream stages.
REQ-013 out_valid  out  1  M slot valid toward WB.
REQ-014 out_pc4  out  32  registered PC+4.
REQ-015 out_ir  out  32  registered instruction.
REQ-016 out_a3  out  5  registered destination.
REQ-017 out_grf_we  out  1  register write enable toward WB, after exception suppression.
REQ-018 out_wd  out  32  write-back data: load result if re, else registered AO.
REQ-019 mem_to_reg  out  1  valid & re & grf_we, for hazard detection.
REQ-020 exc_code  out  2  0 none, 1 AdEL, 2 AdES, 3 bus error/timeout.
REQ-021 bus_req  out  1  access request, held until ack.
REQ-022 bus_we  out  1  write access.
REQ-023 bus_addr  out  AW  word-aligned address {AO[AW-1:2], 2'b00}.
REQ-024 bus_be  out  4  byte enables.
REQ-025 bus_wdata  out  32  lane-replicated store data.
REQ-026 bus_ack  in  1  access complete this cycle.
REQ-027 bus_rdata  in  32  read data, valid with bus_ack.
REQ-028 bus_err  in  1  access failed, valid with bus_ack.

Function
REQ-029 The M register SHALL capture all in_* signals on a rising clk edge when stall=0 and hold them when stall=1.
REQ-030 Misalignment (word: AO[1:0]!=0; half: AO[0]!=0) SHALL block the bus access, set exc_code 1 (load) or 2 (store), and force out_grf_we=0.
REQ-031 The FSM SHALL have states IDLE and ACCESS; capturing a valid, aligned instruction with re|we SHALL enter ACCESS, otherwise IDLE.
REQ-032 In ACCESS, bus_req SHALL be 1 with bus_addr/bus_we/bus_be/bus_wdata stable; stall SHALL be 1 until the bus_ack cycle.
REQ-033 On bus_ack, stall SHALL be 0 in that cycle, and the FSM SHALL go to ACCESS or IDLE according to the newly captured instruction, which allows back-to-back accesses with zero idle cycles.
REQ-034 bus_be SHALL be 0001<<AO[1:0] for byte, 0011<<AO[1:0] for half, 1111 for word; bus_wdata SHALL be {4{rt[7:0]}}, {2{rt[15:0]}} or rt respectively.
REQ-035 The load result SHALL be bus_rdata>>(8*AO[1:0]), truncated to width, then sign- or zero-extended per ext, and presented combinationally on out_wd in the ack cycle.
REQ-036 bus_ack with bus_err=1 SHALL set exc_code=3 and force out_grf_we=0.
REQ-037 A counter SHALL count ACCESS cycles; reaching TIMEOUT without ack SHALL drop bus_req, set exc_code=3, release stall and return to IDLE.
REQ-038 out_valid SHALL be 1 only when the slot is valid and the FSM is IDLE or acking; a stalled slot SHALL present out_valid=0 to WB.
REQ-039 A bubble (in_valid=0) SHALL produce no bus activity, out_grf_we=0 and mem_to_reg=0.

Reset
REQ-040 rst_n=0 SHALL immediately clear all state: FSM=IDLE, counter=0, M register=0, and therefore bus_req=0, stall=0, out_valid=0, out_grf_we=0 and exc_code=0, including mid-ACCESS.
REQ-041 After reset release, the first capture SHALL occur on the first rising edge with rst_n=1.

Structure
REQ-042 The in_mctl field layout, width codes, exc_code values and FSM encoding SHALL live in the shared constants package.
REQ-043 Byte-lane steering and load extension SHALL be one combinational sub-module, mm_lane.

Verification
REQ-044 lw with AO=0x100 and ack on the 3rd ACCESS cycle -> stall high for 2 cycles, bus_be=1111, out_wd=rdata, out_grf_we=1.
REQ-045 lb with ext=1, AO=0x103, rdata=0x80FF_FFFF -> out_wd=0xFFFF_FF80; with ext=0 -> 0x0000_0080.
REQ-046 sh with AO=0x202, rt=0x1234_ABCD -> bus_be=1100, bus_wdata=0xABCD_ABCD, bus_we=1.
REQ-047 lw with AO=0x101 -> no bus_req, exc_code=1, out_grf_we=0, stall=0.
REQ-048 TIMEOUT=4 with no ack -> bus_req high for exactly 4 cycles, then exc_code=3 and stall=0.
REQ-049 rst_n asserted mid-ACCESS -> bus_req and stall fall without a clock edge, and all outputs are 0.
